// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin write-back arbiter for a 7-source, 32-bit write-back
// mux feeding the register bank.
// Each grant takes three states:
//   IDLE   - pick a winner
//   SETTLE - let the mux output settle; this state may be frozen by stall
//   WRITE  - one-cycle register write and acknowledge
module wb_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  req,
    input  logic [34:0] req_dest,
    input  logic        stall,
    output logic [2:0]  mux_sel,
    output logic        reg_wr,
    output logic [4:0]  reg_dest,
    output logic [6:0]  ack,
    output logic        busy,
    output logic [7:0]  wr_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WRITE  = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  last, last_nxt;
    logic [2:0]  mux_sel_nxt;
    logic [4:0]  reg_dest_nxt;
    logic [7:0]  wr_count_nxt;

    logic        found;
    logic [2:0]  winner;
    logic [4:0]  winner_dest;
    logic        cur_req;

    // Round-robin search: the first set request bit, starting at (last+1) mod 7
    // and wrapping around.
    always_comb begin
        found       = 1'b0;
        winner      = '0;
        winner_dest = '0;
        for (int unsigned off = 1; off <= 7; off++) begin
            int unsigned idx;
            idx = {29'd0, last} + off;
            if (idx >= 7) idx = idx - 7;
            for (int unsigned i = 0; i < 7; i++) begin
                if (!found && idx == i && req[i]) begin
                    found       = 1'b1;
                    winner      = i[2:0];
                    winner_dest = req_dest[5*i +: 5];
                end
            end
        end
    end

    // Request level of the currently latched winner. mux_sel is never 7,
    // so the missing eighth entry is never looked up.
    always_comb begin
        cur_req = 1'b0;
        for (int unsigned i = 0; i < 7; i++) begin
            if (mux_sel == i[2:0]) cur_req = req[i];
        end
    end

    // Next-state logic and next values for the latched selection, the last
    // pointer and the write counter.
    always_comb begin
        state_nxt    = state;
        last_nxt     = last;
        mux_sel_nxt  = mux_sel;
        reg_dest_nxt = reg_dest;
        wr_count_nxt = wr_count;
        case (state)
            IDLE: begin
                if (found) begin
                    mux_sel_nxt  = winner;
                    reg_dest_nxt = winner_dest;
                    state_nxt    = SETTLE;
                end
            end
            SETTLE: begin
                // A withdrawn request aborts the grant, even while stalled.
                if (!cur_req)
                    state_nxt = IDLE;
                else if (!stall)
                    state_nxt = WRITE;
            end
            WRITE: begin
                last_nxt  = mux_sel;
                state_nxt = IDLE;
                if (reg_wr) wr_count_nxt = wr_count + 8'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Write strobe, acknowledge and busy flag. All are decoded from the
    // current state and the latched selection.
    always_comb begin
        ack = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            ack[i] = (state == WRITE) && (mux_sel == i[2:0]);
        end
        reg_wr = (state == WRITE) && (reg_dest != 5'd0);
        busy   = (state != IDLE);
    end

    // State and datapath registers. Reset takes priority over every input,
    // including stall.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            last     <= 3'd6;
            mux_sel  <= '0;
            reg_dest <= '0;
            wr_count <= '0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            mux_sel  <= mux_sel_nxt;
            reg_dest <= reg_dest_nxt;
            wr_count <= wr_count_nxt;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios for wb_arbiter.
// Each scenario has hand-computed expected values.
module tb_wb_arbiter;

    logic        clk;
    logic        reset_n;
    logic [6:0]  req;
    logic [34:0] req_dest;
    logic        stall;
    logic [2:0]  mux_sel;
    logic        reg_wr;
    logic [4:0]  reg_dest;
    logic [6:0]  ack;
    logic        busy;
    logic [7:0]  wr_count;

    int checks;
    int errors;

    wb_arbiter dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .req_dest (req_dest),
        .stall    (stall),
        .mux_sel  (mux_sel),
        .reg_wr   (reg_wr),
        .reg_dest (reg_dest),
        .ack      (ack),
        .busy     (busy),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        req = '0; req_dest = '0; stall = 1'b0;
        do_reset();
        checks++;
        if ({busy, mux_sel, reg_dest, reg_wr, ack, wr_count} !== 24'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b sel=%0d dest=%0d wr=%b ack=%b cnt=%0d want all 0",
                     busy, mux_sel, reg_dest, reg_wr, ack, wr_count);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || mux_sel !== 3'd0) begin
            errors++;
            $display("FAIL idle_no_req got busy=%b sel=%0d want busy=0 sel=0", busy, mux_sel);
        end
    endtask

    task automatic test_single();
        req = 7'b0000100;
        req_dest = '0;
        req_dest[14:10] = 5'd9;
        tick();  // SETTLE
        checks++;
        if (busy !== 1'b1 || mux_sel !== 3'd2 || reg_dest !== 5'd9 || reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL single_settle got busy=%b sel=%0d dest=%0d wr=%b want 1/2/9/0",
                     busy, mux_sel, reg_dest, reg_wr);
        end
        tick();  // WRITE
        checks++;
        if (reg_wr !== 1'b1 || ack !== 7'b0000100 || mux_sel !== 3'd2) begin
            errors++;
            $display("FAIL single_write got wr=%b ack=%b sel=%0d want 1/0000100/2", reg_wr, ack, mux_sel);
        end
        req = '0;
        tick();  // IDLE
        checks++;
        if (wr_count !== 8'd1 || reg_wr !== 1'b0 || ack !== 7'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_done got cnt=%0d wr=%b ack=%b busy=%b want 1/0/0/0",
                     wr_count, reg_wr, ack, busy);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_sel [4];
        exp_sel[0] = 3'd0; exp_sel[1] = 3'd6; exp_sel[2] = 3'd0; exp_sel[3] = 3'd6;
        req = '0;
        do_reset();
        req = 7'b1000001;
        req_dest = '0;
        req_dest[4:0]   = 5'd3;
        req_dest[34:30] = 5'd4;
        for (int g = 0; g < 4; g++) begin
            tick();  // SETTLE
            checks++;
            if (mux_sel !== exp_sel[g]) begin
                errors++;
                $display("FAIL rr_sel[%0d] got %0d want %0d", g, mux_sel, exp_sel[g]);
            end
            tick();  // WRITE
            checks++;
            if (ack !== (7'd1 << exp_sel[g])) begin
                errors++;
                $display("FAIL rr_ack[%0d] got %b want %b", g, ack, 7'd1 << exp_sel[g]);
            end
            tick();  // IDLE
        end
        req = '0;
        checks++;
        if (wr_count !== 8'd4) begin
            errors++;
            $display("FAIL rr_count got %0d want 4", wr_count);
        end
    endtask

    task automatic test_wrap();
        // last pointer is 6 here
        req = 7'b0110000;
        req_dest = '0;
        req_dest[24:20] = 5'd7;
        req_dest[29:25] = 5'd8;
        tick();
        checks++;
        if (mux_sel !== 3'd4 || reg_dest !== 5'd7) begin
            errors++;
            $display("FAIL wrap_first got sel=%0d dest=%0d want 4/7", mux_sel, reg_dest);
        end
        tick();
        req = '0;
        tick();
        req = 7'b0000011;
        req_dest[4:0] = 5'd11;
        req_dest[9:5] = 5'd12;
        tick();
        checks++;
        if (mux_sel !== 3'd0 || reg_dest !== 5'd11) begin
            errors++;
            $display("FAIL wrap_second got sel=%0d dest=%0d want 0/11", mux_sel, reg_dest);
        end
        tick();
        req = '0;
        tick();
    endtask

    task automatic test_stall_withdraw();
        logic [7:0] cnt0;
        int wr_seen;
        cnt0 = wr_count;
        wr_seen = 0;
        // last pointer is 0 here
        req = 7'b0001000;
        req_dest = '0;
        req_dest[19:15] = 5'd13;
        stall = 1'b1;
        tick();  // SETTLE with source 3
        checks++;
        if (mux_sel !== 3'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_grant got sel=%0d busy=%b want 3/1", mux_sel, busy);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            if (reg_wr !== 1'b0 || busy !== 1'b1) wr_seen++;
        end
        checks++;
        if (wr_seen != 0) begin
            errors++;
            $display("FAIL stall_hold got %0d bad cycles want 0", wr_seen);
        end
        req = '0;
        tick();
        checks++;
        if (busy !== 1'b0 || ack !== 7'd0 || reg_wr !== 1'b0 || wr_count !== cnt0) begin
            errors++;
            $display("FAIL withdraw got busy=%b ack=%b wr=%b cnt=%0d want 0/0/0/%0d",
                     busy, ack, reg_wr, wr_count, cnt0);
        end
        stall = 1'b0;
        // last pointer still 0, so source 3 beats source 0
        req = 7'b0001001;
        tick();
        checks++;
        if (mux_sel !== 3'd3) begin
            errors++;
            $display("FAIL withdraw_last got sel=%0d want 3", mux_sel);
        end
        tick();
        req = '0;
        tick();
    endtask

    task automatic test_reg0();
        logic [7:0] cnt0;
        cnt0 = wr_count;
        req = 7'b0000010;
        req_dest = '0;
        tick();
        tick();  // WRITE
        checks++;
        if (ack !== 7'b0000010 || reg_wr !== 1'b0) begin
            errors++;
            $display("FAIL reg0_write got ack=%b wr=%b want 0000010/0", ack, reg_wr);
        end
        req = '0;
        tick();
        checks++;
        if (wr_count !== cnt0) begin
            errors++;
            $display("FAIL reg0_count got %0d want %0d", wr_count, cnt0);
        end
    endtask

    task automatic test_reset_mid_grant();
        req = 7'b0100000;
        req_dest = '0;
        req_dest[29:25] = 5'd17;
        tick();  // SETTLE, would enter WRITE next
        reset_n = 1'b0;
        stall = 1'b1;
        tick();
        checks++;
        if ({busy, mux_sel, reg_dest, reg_wr, ack, wr_count} !== 24'd0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b sel=%0d dest=%0d wr=%b ack=%b cnt=%0d want all 0",
                     busy, mux_sel, reg_dest, reg_wr, ack, wr_count);
        end
        reset_n = 1'b1;
        stall = 1'b0;
        req = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        req = 7'b0000001;
        req_dest = '0;
        req_dest[4:0] = 5'd1;
        for (int n = 1; n <= 256; n++) begin
            tick();
            tick();
            if (reg_wr === 1'b1) pulses++;
            tick();
            if (n == 255) begin
                checks++;
                if (wr_count !== 8'd255) begin
                    errors++;
                    $display("FAIL count_255 got %0d want 255", wr_count);
                end
            end
        end
        req = '0;
        checks++;
        if (pulses != 256) begin
            errors++;
            $display("FAIL b2b_pulses got %0d want 256", pulses);
        end
        checks++;
        if (wr_count !== 8'd0) begin
            errors++;
            $display("FAIL count_wrap got %0d want 0", wr_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b1;
        req = '0;
        req_dest = '0;
        stall = 1'b0;
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_stall_withdraw();
        test_reg0();
        test_reset_mid_grant();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
